// File: rtl/dm_pkg.sv
// Shared constants for the debug-module abstract command path: debug-ROM entry
// points, cmderr codes, special register numbers and the sequencer state encoding.
package dm_pkg;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXC        = 3'd3,
        CMDERR_HALTRESUME = 3'd4,
        CMDERR_OTHER      = 3'd7
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    localparam logic [7:0]  CMDTYPE_REG = 8'd0;
    localparam logic [7:0]  CMDTYPE_MEM = 8'd2;

    localparam logic [15:0] REGNO_S0  = 16'h1008;
    localparam logic [15:0] REGNO_S1  = 16'h1009;
    localparam logic [15:0] REGNO_DPC = 16'h07b1;
    localparam logic [15:0] REGNO_MAX = 16'h101f;

    // Debug-ROM program entry byte addresses, read / write variants.
    localparam logic [9:0] ENTRY_S0_RD  = 10'h13c;
    localparam logic [9:0] ENTRY_S0_WR  = 10'h100;
    localparam logic [9:0] ENTRY_S1_RD  = 10'h150;
    localparam logic [9:0] ENTRY_S1_WR  = 10'h114;
    localparam logic [9:0] ENTRY_GPR_RD = 10'h160;
    localparam logic [9:0] ENTRY_GPR_WR = 10'h128;
    localparam logic [9:0] ENTRY_DPC_RD = 10'h19c;
    localparam logic [9:0] ENTRY_DPC_WR = 10'h170;
    localparam logic [9:0] ENTRY_CSR_RD = 10'h1ac;
    localparam logic [9:0] ENTRY_CSR_WR = 10'h184;
    localparam logic [9:0] ENTRY_MEM_RD = 10'h1ec;
    localparam logic [9:0] ENTRY_MEM_WR = 10'h1d0;

    function automatic logic [9:0] pick_entry(input logic write,
                                              input logic [9:0] rd_addr,
                                              input logic [9:0] wr_addr);
        return write ? wr_addr : rd_addr;
    endfunction

endpackage

// File: rtl/dm_cmd_decode.sv
// Combinational abstract-command decode: legality check with first-match error
// priority, debug-ROM entry address and the register field patched into the ROM.
module dm_cmd_decode
    import dm_pkg::*;
(
    input  logic [7:0]  cmd_type,
    input  logic [2:0]  cmd_size,
    input  logic [15:0] cmd_regno,
    input  logic        cmd_write,
    input  logic        hart_halted,
    output logic [2:0]  dec_err,
    output logic [9:0]  dec_entry,
    output logic [11:0] dec_fix_reg
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec_err     = CMDERR_NONE;
        dec_entry   = '0;
        dec_fix_reg = '0;
        if (!hart_halted) begin
            dec_err = CMDERR_HALTRESUME;
        end else if (cmd_type == CMDTYPE_REG) begin
            if (cmd_size != 3'd2) begin
                dec_err = CMDERR_NOTSUP;
            end else if (cmd_regno > REGNO_MAX) begin
                dec_err = CMDERR_EXC;
            end else if (cmd_regno == REGNO_S0) begin
                dec_entry = pick_entry(cmd_write, ENTRY_S0_RD, ENTRY_S0_WR);
            end else if (cmd_regno == REGNO_S1) begin
                dec_entry = pick_entry(cmd_write, ENTRY_S1_RD, ENTRY_S1_WR);
            end else if (cmd_regno[15:12] == 4'h1) begin
                // Only 0x1000-0x101f survive the range check here: the GPR file.
                dec_entry   = pick_entry(cmd_write, ENTRY_GPR_RD, ENTRY_GPR_WR);
                dec_fix_reg = {7'd0, cmd_regno[4:0]};
            end else if (cmd_regno == REGNO_DPC) begin
                dec_entry = pick_entry(cmd_write, ENTRY_DPC_RD, ENTRY_DPC_WR);
            end else begin
                dec_entry   = pick_entry(cmd_write, ENTRY_CSR_RD, ENTRY_CSR_WR);
                dec_fix_reg = cmd_regno[11:0];
            end
        end else if (cmd_type == CMDTYPE_MEM) begin
            if (cmd_size > 3'd2) begin
                dec_err = CMDERR_NOTSUP;
            end else begin
                dec_entry = pick_entry(cmd_write, ENTRY_MEM_RD, ENTRY_MEM_WR);
            end
        end else begin
            dec_err = CMDERR_NOTSUP;
        end
    end

endmodule

// File: rtl/dm_cmd_seq.sv
// Abstract command sequencer: IDLE -> ISSUE -> WAIT, sticky cmderr, ROM patch fields.
// Optional WAIT timeout is built only when DM_CMD_TIMEOUT_EN is defined.
module dm_cmd_seq
    import dm_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_type,
    input  logic [2:0]  cmd_size,
    input  logic [15:0] cmd_regno,
    input  logic        cmd_write,
    input  logic        cmd_transfer,
    input  logic [2:0]  cmderr_clr,
    input  logic        hart_halted,
    input  logic        hart_done,
    input  logic        hart_exception,
    output logic        go,
    output logic [9:0]  entry_addr,
    output logic [11:0] fix_reg,
    output logic [1:0]  fix_size,
    output logic        busy,
    output logic        cmd_ready,
    output logic [2:0]  cmderr
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    seq_state_e  state;
    logic [2:0]  dec_err;
    logic [9:0]  dec_entry;
    logic [11:0] dec_fix_reg;
    logic        accept;
    logic        timeout_hit;
    logic [2:0]  cmderr_cleared;
    logic [2:0]  cmderr_set;
    logic [2:0]  cmderr_next;

    dm_cmd_decode u_decode (
        .cmd_type    (cmd_type),
        .cmd_size    (cmd_size),
        .cmd_regno   (cmd_regno),
        .cmd_write   (cmd_write),
        .hart_halted (hart_halted),
        .dec_err     (dec_err),
        .dec_entry   (dec_entry),
        .dec_fix_reg (dec_fix_reg)
    );

    assign accept    = cmd_valid && (state == ST_IDLE) && (cmderr == CMDERR_NONE);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

`ifdef DM_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && !hart_exception && !hart_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // The clear mask acts first, so a set in the same cycle can land on a freshly cleared field.
    always_comb begin
        cmderr_cleared = cmderr & ~cmderr_clr;
        cmderr_set     = CMDERR_NONE;
        if (cmd_valid && (state != ST_IDLE)) begin
            cmderr_set = CMDERR_BUSY;
        end else if (accept) begin
            cmderr_set = dec_err;
        end else if ((state == ST_WAIT) && hart_exception) begin
            cmderr_set = CMDERR_EXC;
        end else if (timeout_hit) begin
            cmderr_set = CMDERR_OTHER;
        end
        cmderr_next = (cmderr_cleared == CMDERR_NONE) ? cmderr_set : cmderr_cleared;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            go         <= 1'b0;
            cmderr     <= CMDERR_NONE;
            entry_addr <= '0;
            fix_reg    <= '0;
            fix_size   <= '0;
        end else begin
            go     <= 1'b0;
            cmderr <= cmderr_next;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        entry_addr <= dec_entry;
                        fix_reg    <= dec_fix_reg;
                        fix_size   <= cmd_size[1:0];
                        if (dec_err == CMDERR_NONE) begin
                            state <= ST_ISSUE;
                            go    <= cmd_transfer;
                        end
                    end
                end
                // go is high in ISSUE exactly when the command transfers.
                ST_ISSUE: state <= go ? ST_WAIT : ST_IDLE;
                ST_WAIT: begin
                    if (hart_exception || hart_done || timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
